// File: rtl/dcsk_pkg.sv
// Shared types and constants for the DCSK transmit request controller.
package dcsk_pkg;

  localparam int MSG_W  = 32;
  localparam int SEED_W = 8;
  localparam int N_REQ  = 2;

  typedef logic [1:0] sf_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    SEND       = 3'd2,
    WAIT_START = 3'd3,
    WAIT_DONE  = 3'd4
  } state_t;

  // Grants are one-hot over two requesters, so the index is just the upper bit.
  function automatic logic grant_to_idx(input logic [N_REQ-1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/dcsk_rr_arb.sv
// Two-requester round-robin arbiter; the priority pointer moves past whoever was granted.
module dcsk_rr_arb
  import dcsk_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant
);

  logic ptr_r;

  // Combinational grant: on contention the pointer decides, otherwise the lone requester wins.
  always_comb begin
    grant = 2'b00;
    if (!en) begin
      grant = 2'b00;
    end else if (req == 2'b11) begin
      grant = ptr_r ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
  end

  // Priority pointer update: an accepted grant hands priority to the other requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (grant == 2'b01) begin
      ptr_r <= 1'b1;
    end else if (grant == 2'b10) begin
      ptr_r <= 1'b0;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/dcsk_tx_ctrl.sv
// Arbitrates two transfer requesters onto one DCSK transmitter and sequences
// seed load, send strobe, start timeout and completion reporting.
module dcsk_tx_ctrl
  import dcsk_pkg::*;
#(
  parameter int START_TIMEOUT = 16
) (
  input  logic                    i_clk,
  input  logic                    i_arst_n,
  input  logic [N_REQ-1:0]        i_req_valid,
  output logic [N_REQ-1:0]        o_req_ready,
  input  logic [N_REQ*MSG_W-1:0]  i_req_msg,
  input  logic [N_REQ*2-1:0]      i_req_sf,
  input  logic [N_REQ*SEED_W-1:0] i_req_seed,
  output logic [MSG_W-1:0]        o_msg,
  output logic [1:0]              o_sf,
  output logic [SEED_W-1:0]       o_seed,
  output logic                    o_load_seed,
  output logic                    o_send,
  input  logic                    i_is_sending,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic                    o_id
);

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(START_TIMEOUT);

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               arb_en_s;
  logic [N_REQ-1:0]   grant_s;
  logic               sel_idx_s;
  logic [MSG_W-1:0]   sel_msg_s;
  sf_t                sel_sf_s;
  logic [SEED_W-1:0]  sel_seed_s;

  // Requests are only offered while idle and the transmitter is quiet.
  always_comb begin
    arb_en_s = 1'b0;
    if (i_arst_n && (state_r == IDLE) && !i_is_sending) begin
      arb_en_s = 1'b1;
    end else begin
      arb_en_s = 1'b0;
    end
  end

  dcsk_rr_arb u_arb (
    .clk   (i_clk),
    .rst_n (i_arst_n),
    .en    (arb_en_s),
    .req   (i_req_valid),
    .grant (grant_s)
  );

  assign o_req_ready = grant_s;

  // Payload mux for the granted requester.
  always_comb begin
    sel_idx_s  = grant_to_idx(grant_s);
    sel_msg_s  = i_req_msg[MSG_W-1:0];
    sel_sf_s   = i_req_sf[1:0];
    sel_seed_s = i_req_seed[SEED_W-1:0];
    if (sel_idx_s) begin
      sel_msg_s  = i_req_msg[2*MSG_W-1:MSG_W];
      sel_sf_s   = i_req_sf[3:2];
      sel_seed_s = i_req_seed[2*SEED_W-1:SEED_W];
    end else begin
      sel_msg_s  = i_req_msg[MSG_W-1:0];
      sel_sf_s   = i_req_sf[1:0];
      sel_seed_s = i_req_seed[SEED_W-1:0];
    end
  end

  // Transfer sequencer; every output is registered and strobes default low.
  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_W'(0);
      o_msg       <= {MSG_W{1'b0}};
      o_sf        <= 2'b00;
      o_seed      <= {SEED_W{1'b0}};
      o_load_seed <= 1'b0;
      o_send      <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_id        <= 1'b0;
    end else begin
      o_load_seed <= 1'b0;
      o_send      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (|grant_s) begin
            o_msg       <= sel_msg_s;
            o_sf        <= sel_sf_s;
            o_seed      <= sel_seed_s;
            o_id        <= sel_idx_s;
            o_load_seed <= 1'b1;
            o_busy      <= 1'b1;
            state_r     <= LOAD;
          end else begin
            o_busy      <= 1'b0;
          end
        end
        LOAD: begin
          o_send  <= 1'b1;
          state_r <= SEND;
        end
        SEND: begin
          cnt_r   <= CNT_W'(0);
          state_r <= WAIT_START;
        end
        WAIT_START: begin
          // A late start still wins over the timeout on the final cycle.
          if (i_is_sending) begin
            state_r <= WAIT_DONE;
          end else if (cnt_r == CNT_LAST) begin
            o_err   <= 1'b1;
            o_busy  <= 1'b0;
            state_r <= IDLE;
          end else if (cnt_r != CNT_MAX) begin
            cnt_r   <= cnt_r + CNT_W'(1);
          end else begin
            cnt_r   <= cnt_r;
          end
        end
        WAIT_DONE: begin
          if (!i_is_sending) begin
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_DONE;
          end
        end
        default: begin
          o_busy  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcsk_tx_ctrl.sv
// Self-checking bench: directed scenarios followed by random traffic, all compared
// cycle by cycle against a transaction-level model of the controller.
module tb_dcsk_tx_ctrl;

  localparam int NC = 3000;

  logic        i_clk = 1'b0;
  logic        i_arst_n = 1'b0;
  logic [1:0]  i_req_valid = 2'b00;
  logic [63:0] i_req_msg = 64'd0;
  logic [3:0]  i_req_sf = 4'd0;
  logic [15:0] i_req_seed = 16'd0;
  logic        i_is_sending = 1'b0;
  logic [1:0]  o_req_ready;
  logic [31:0] o_msg;
  logic [1:0]  o_sf;
  logic [7:0]  o_seed;
  logic        o_load_seed, o_send, o_busy, o_done, o_err, o_id;

  dcsk_tx_ctrl #(.START_TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_msg(i_req_msg), .i_req_sf(i_req_sf), .i_req_seed(i_req_seed),
    .o_msg(o_msg), .o_sf(o_sf), .o_seed(o_seed), .o_load_seed(o_load_seed), .o_send(o_send),
    .i_is_sending(i_is_sending), .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_id(o_id)
  );

  always #5 i_clk = ~i_clk;

  // stimulus per cycle
  bit          rst_a [NC];
  logic [1:0]  v_a   [NC];
  logic [31:0] m0_a  [NC];
  logic [31:0] m1_a  [NC];
  logic [1:0]  f0_a  [NC];
  logic [1:0]  f1_a  [NC];
  logic [7:0]  s0_a  [NC];
  logic [7:0]  s1_a  [NC];
  bit          is_a  [NC];

  // expectations: ready before edge c, registered outputs after edge c
  logic [1:0]  er_a [NC];
  bit          el_a [NC];
  bit          es_a [NC];
  bit          ed_a [NC];
  bit          ee_a [NC];
  bit          eb_a [NC];
  bit          ei_a [NC];
  logic [31:0] em_a [NC];
  logic [1:0]  ef_a [NC];
  logic [7:0]  ek_a [NC];

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic void set_exp(input int c, input logic [1:0] r, input bit l, input bit s,
                                  input bit d, input bit e, input bit b, input bit id,
                                  input logic [31:0] m, input logic [1:0] f, input logic [7:0] k);
    er_a[c] = r; el_a[c] = l; es_a[c] = s; ed_a[c] = d; ee_a[c] = e; eb_a[c] = b;
    ei_a[c] = id; em_a[c] = m; ef_a[c] = f; ek_a[c] = k;
  endfunction

  task automatic gen_stim();
    logic [1:0] vv;
    bit lvl;
    int seglen;
    for (int c = 0; c < NC; c++) begin
      rst_a[c] = 1'b1; v_a[c] = 2'b00; is_a[c] = 1'b0;
      m0_a[c] = $urandom(); m1_a[c] = $urandom();
      f0_a[c] = 2'($urandom_range(0, 3)); f1_a[c] = 2'($urandom_range(0, 3));
      s0_a[c] = 8'($urandom_range(0, 255)); s1_a[c] = 8'($urandom_range(0, 255));
    end
    // single request, normal completion
    rst_a[0] = 1'b0; rst_a[1] = 1'b0;
    v_a[2] = 2'b01; m0_a[2] = 32'hDEADBEEF; f0_a[2] = 2'd2; s0_a[2] = 8'h5A;
    for (int c = 6; c <= 10; c++) is_a[c] = 1'b1;
    // start timeout on requester 1
    v_a[15] = 2'b10; m1_a[15] = 32'h12345678; f1_a[15] = 2'd1; s1_a[15] = 8'h33;
    // contention right after a reset
    rst_a[40] = 1'b0;
    for (int c = 41; c <= 60; c++) v_a[c] = 2'b11;
    is_a[44] = 1'b1; is_a[49] = 1'b1; is_a[54] = 1'b1; is_a[59] = 1'b1;
    // reset while waiting for done, then a clean transfer
    v_a[65] = 2'b01;
    for (int c = 68; c <= 75; c++) is_a[c] = 1'b1;
    rst_a[72] = 1'b0;
    v_a[78] = 2'b01; is_a[81] = 1'b1;
    // transmitter busy while idle blocks the ready
    for (int c = 85; c <= 91; c++) v_a[c] = 2'b10;
    for (int c = 85; c <= 90; c++) is_a[c] = 1'b1;
    is_a[94] = 1'b1;
    // random traffic
    vv = 2'b00; lvl = 1'b0; seglen = 0;
    for (int c = 100; c < NC; c++) begin
      rst_a[c] = ($urandom_range(0, 399) != 0);
      for (int b = 0; b < 2; b++) if ($urandom_range(0, 4) == 0) vv[b] = ~vv[b];
      v_a[c] = vv;
      if (seglen == 0) begin
        lvl = ($urandom_range(0, 9) < 4);
        seglen = $urandom_range(1, 24);
      end
      is_a[c] = lvl;
      seglen--;
    end
  endtask

  // Transaction-level model: find each accept, then derive the whole transfer timeline from is_a.
  task automatic run_model();
    int c, e, s, endc;
    bit kdone;
    logic p, idx, hid;
    logic [1:0] g;
    logic [31:0] hm;
    logic [1:0] hf;
    logic [7:0] hk;
    c = 0; p = 1'b0; hid = 1'b0; hm = 32'd0; hf = 2'd0; hk = 8'd0;
    while (c < NC) begin
      if (!rst_a[c]) begin
        p = 1'b0; hid = 1'b0; hm = 32'd0; hf = 2'd0; hk = 8'd0;
        set_exp(c, 2'b00, 0, 0, 0, 0, 0, hid, hm, hf, hk);
        c++;
      end else begin
        g = 2'b00;
        if (!is_a[c]) begin
          if (v_a[c] == 2'b11) g = p ? 2'b10 : 2'b01;
          else g = v_a[c];
        end
        if (g == 2'b00) begin
          set_exp(c, g, 0, 0, 0, 0, 0, hid, hm, hf, hk);
          c++;
        end else begin
          idx = g[1];
          hm = idx ? m1_a[c] : m0_a[c];
          hf = idx ? f1_a[c] : f0_a[c];
          hk = idx ? s1_a[c] : s0_a[c];
          hid = idx; p = ~idx;
          s = -1;
          for (int k = 3; k <= 18; k++) if (s < 0 && c + k < NC && is_a[c + k]) s = c + k;
          if (s >= 0) begin
            endc = s + 1;
            while (endc < NC && is_a[endc]) endc++;
            kdone = 1'b1;
          end else begin
            endc = c + 18;
            kdone = 1'b0;
          end
          e = c;
          while (e <= endc && e < NC && (e == c || rst_a[e])) begin
            set_exp(e, (e == c) ? g : 2'b00, e == c, e == c + 1, kdone && e == endc,
                    !kdone && e == endc, e != endc, hid, hm, hf, hk);
            e++;
          end
          c = e;
        end
      end
    end
  endtask

  initial begin
    int ndone;
    gen_stim();
    run_model();
    // hand-computed pins on the model
    chk("pin_ready_single", 2, 32'(er_a[2]), 32'h1);
    chk("pin_load_single", 2, 32'(el_a[2]), 32'h1);
    chk("pin_seed_single", 2, 32'(ek_a[2]), 32'h5A);
    chk("pin_send_single", 3, 32'(es_a[3]), 32'h1);
    chk("pin_done_single", 11, 32'(ed_a[11]), 32'h1);
    chk("pin_id_single", 11, 32'(ei_a[11]), 32'h0);
    chk("pin_err_early", 32, 32'(ee_a[32]), 32'h0);
    chk("pin_err_timeout", 33, 32'(ee_a[33]), 32'h1);
    chk("pin_id_timeout", 33, 32'(ei_a[33]), 32'h1);
    chk("pin_rr0", 41, 32'(er_a[41]), 32'h1);
    chk("pin_rr1", 46, 32'(er_a[46]), 32'h2);
    chk("pin_rr2", 51, 32'(er_a[51]), 32'h1);
    chk("pin_rr3", 56, 32'(er_a[56]), 32'h2);
    chk("pin_busy_reset", 72, 32'(eb_a[72]), 32'h0);
    chk("pin_done_after_reset", 82, 32'(ed_a[82]), 32'h1);
    chk("pin_blocked_ready", 90, 32'(er_a[90]), 32'h0);
    chk("pin_unblocked_ready", 91, 32'(er_a[91]), 32'h2);
    ndone = 0;
    for (int c = 65; c <= 77; c++) ndone += int'(ed_a[c]) + int'(ee_a[c]);
    chk("pin_silent_abort", 77, 32'(ndone), 32'h0);

    // per-cycle comparison of the DUT against the model
    for (int c = 0; c < NC; c++) begin
      @(negedge i_clk);
      i_arst_n     = rst_a[c];
      i_req_valid  = v_a[c];
      i_req_msg    = {m1_a[c], m0_a[c]};
      i_req_sf     = {f1_a[c], f0_a[c]};
      i_req_seed   = {s1_a[c], s0_a[c]};
      i_is_sending = is_a[c];
      #1;
      chk("ready", c, 32'(o_req_ready), 32'(er_a[c]));
      @(posedge i_clk);
      #1;
      chk("load_seed", c, 32'(o_load_seed), 32'(el_a[c]));
      chk("send", c, 32'(o_send), 32'(es_a[c]));
      chk("done", c, 32'(o_done), 32'(ed_a[c]));
      chk("err", c, 32'(o_err), 32'(ee_a[c]));
      chk("busy", c, 32'(o_busy), 32'(eb_a[c]));
      if (ed_a[c] || ee_a[c]) chk("id", c, 32'(o_id), 32'(ei_a[c]));
      if (eb_a[c] || !rst_a[c]) begin
        chk("msg", c, o_msg, em_a[c]);
        chk("sf", c, 32'(o_sf), 32'(ef_a[c]));
        chk("seed", c, 32'(o_seed), 32'(ek_a[c]));
      end
      if (!rst_a[c]) chk("id_reset", c, 32'(o_id), 32'h0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
